// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, default reset PC and the branch
// target computation used by the fetch path.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Target math is done at the widest supported width; callers truncate,
  // which gives the modulo-2^WIDTH result for any WIDTH <= TGT_W.
  localparam int TGT_W = 64;
  typedef logic [TGT_W-1:0] tgt_t;

  function automatic tgt_t branch_target(input tgt_t pc, input logic [11:0] imm);
    return pc + {{(TGT_W-13){imm[11]}}, imm, 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two FIFO of {pc, instr} entries with
// push/pop/flush and full/empty/count status.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_pc,
  input  logic [WIDTH-1:0] push_instr,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_pc,
  output logic [WIDTH-1:0] head_instr,
  output logic             full,
  output logic             empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign head_pc    = mem_q[rd_ptr_q].pc;
  assign head_instr = mem_q[rd_ptr_q].instr;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage is not reset; count/pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= '{pc: push_pc, instr: push_instr};
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request generator, in-order response
// buffering, and redirect handling that discards responses still in flight.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH    = XLEN,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             redirect,
  input  logic [11:0]      redirect_imm,
  input  logic [WIDTH-1:0] redirect_pc
);

  localparam int               CW   = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] STEP = WIDTH'(4);

  logic             req_valid_q, req_valid_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WIDTH-1:0] next_pc_q, next_pc_d;
  logic [WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]    inflight_q, inflight_d;
  logic [CW-1:0]    discard_q, discard_d;
  logic             stale_q, stale_d;

  logic             accept, hold, rsp_keep, fifo_pop;
  logic [WIDTH-1:0] target, base_pc;
  logic [CW-1:0]    fifo_count, fifo_count_next;
  logic [CW:0]      occupancy;
  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] head_pc, head_instr;

  assign target = WIDTH'(branch_target(TGT_W'(redirect_pc), redirect_imm));

  always_comb begin
    accept   = req_valid_q && imem_req_ready;
    hold     = req_valid_q && !imem_req_ready;
    rsp_keep = imem_rsp_valid && !redirect && (discard_q == '0);
    fifo_pop = instr_ready && !redirect;
    base_pc  = redirect ? target : next_pc_q;

    fifo_count_next = redirect ? '0
                    : fifo_count + CW'(rsp_keep && !fifo_full) - CW'(fifo_pop && !fifo_empty);
    inflight_d = inflight_q + CW'(accept) - CW'(imem_rsp_valid);
    occupancy  = {1'b0, fifo_count_next} + {1'b0, inflight_d};

    req_valid_d = 1'b0;
    req_addr_d  = req_addr_q;
    next_pc_d   = base_pc;
    rsp_pc_d    = rsp_pc_q;
    stale_d     = stale_q;

    // Every response still owed at a redirect belongs to the old path.
    if (redirect) begin
      discard_d = inflight_d;
    end else begin
      discard_d = discard_q - CW'(imem_rsp_valid && (discard_q != '0)) + CW'(accept && stale_q);
    end

    // A request held across a redirect still goes out at its old address and
    // its response is dropped once it is accepted.
    if (accept) stale_d = 1'b0;
    if (redirect && hold) stale_d = 1'b1;

    if (hold) begin
      req_valid_d = 1'b1;
    end else if (occupancy < (CW+1)'(DEPTH)) begin
      req_valid_d = 1'b1;
      req_addr_d  = base_pc;
      next_pc_d   = base_pc + STEP;
    end

    if (redirect)      rsp_pc_d = target;
    else if (rsp_keep) rsp_pc_d = rsp_pc_q + STEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= RESET_PC;
      next_pc_q   <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      inflight_q  <= '0;
      discard_q   <= '0;
      stale_q     <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      next_pc_q   <= next_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      stale_q     <= stale_d;
    end
  end

  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (rsp_keep),
    .push_pc    (rsp_pc_q),
    .push_instr (imem_rsp_data),
    .pop        (fifo_pop),
    .flush      (redirect),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign instr_valid    = !fifo_empty;
  assign instr          = fifo_empty ? '0 : head_instr;
  assign instr_pc       = fifo_empty ? '0 : head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table for the start-up sequence
// plus directed sequences for backpressure, redirects and mid-run reset.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 2;
  localparam logic [31:0] NONE = 32'hDEAD_DEAD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req_valid, imem_req_ready;
  logic [W-1:0]  imem_req_addr;
  logic          imem_rsp_valid;
  logic [W-1:0]  imem_rsp_data;
  logic          instr_valid, instr_ready;
  logic [W-1:0]  instr, instr_pc;
  logic          redirect;
  logic [11:0]   redirect_imm;
  logic [W-1:0]  redirect_pc;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(W), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect       (redirect),
    .redirect_imm   (redirect_imm),
    .redirect_pc    (redirect_pc)
  );

  int tests = 0;
  int fails = 0;

  // Memory model: fixed latency, in-order, one response per cycle.
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } pop_t;
  mreq_t       mq[$];
  pop_t        pop_log[$];
  logic [31:0] acc_log[$];
  int          lat = 1;
  int          cyc_cnt = 0;
  logic        acc_now;
  logic [31:0] acc_addr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return NONE;
  endfunction

  function automatic logic [31:0] pop_pc(input int i);
    if (i < pop_log.size()) return pop_log[i].pc;
    return NONE;
  endfunction

  function automatic logic [31:0] pop_ins(input int i);
    if (i < pop_log.size()) return pop_log[i].ins;
    return NONE;
  endfunction

  always begin
    @(negedge clk);
    acc_now  = imem_req_valid && imem_req_ready && !rst;
    acc_addr = imem_req_addr;
    if (acc_now) acc_log.push_back(acc_addr);
    if (!rst && instr_valid && instr_ready && !redirect) pop_log.push_back('{instr_pc, instr});
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else begin
      cyc_cnt++;
      if (acc_now) mq.push_back('{acc_addr, cyc_cnt + lat - 1});
      if (mq.size() > 0 && mq[0].due <= cyc_cnt) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mdata(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // Leaves the bench 3 time units into the first cycle after release.
  task automatic do_reset(input int l);
    rst            = 1'b1;
    redirect       = 1'b0;
    redirect_imm   = '0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    lat            = l;
    run(3);
    #2;
    rst = 1'b0;
    acc_log.delete();
    pop_log.delete();
  endtask

  task automatic do_redirect(input logic [31:0] pc, input logic [11:0] imm);
    redirect     = 1'b1;
    redirect_pc  = pc;
    redirect_imm = imm;
    acc_log.delete();
    pop_log.delete();
    cyc();
    redirect = 1'b0;
  endtask

  typedef struct {
    logic        ready;
    logic        iready;
    logic        chk_rv;
    logic        exp_rv;
    logic        chk_addr;
    logic [31:0] exp_addr;
    logic        exp_iv;
    logic        chk_data;
    logic [31:0] exp_pc;
    logic [31:0] exp_ins;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;

    // Start-up cycles after release, 1-cycle memory, decode always ready.
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, mdata(32'h0)};

    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    redirect       = 1'b0;
    redirect_imm   = '0;
    redirect_pc    = '0;

    // Outputs while reset is held.
    run(2);
    check("rst_hold_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_hold_req_addr", imem_req_addr, 32'h0);
    check("rst_hold_instr_valid", 32'(instr_valid), 32'd0);

    // Start-up sequence.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      imem_req_ready = vecs[i].ready;
      instr_ready    = vecs[i].iready;
      @(negedge clk);
      if (vecs[i].chk_rv)   check($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_rv));
      if (vecs[i].chk_addr) check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].exp_iv));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].exp_pc);
        check($sformatf("vec%0d_instr", i), instr, vecs[i].exp_ins);
      end
      cyc();
    end
    run(10);
    check("seq_req0", acc_at(0), 32'h0);
    check("seq_req1", acc_at(1), 32'h4);
    check("seq_req2", acc_at(2), 32'h8);
    check("seq_pc1", pop_pc(1), 32'h4);
    check("seq_pc2", pop_pc(2), 32'h8);
    check("seq_ins2", pop_ins(2), mdata(32'h8));

    // Decode stalled: buffer fills to DEPTH, requests stop, then drains in order.
    do_reset(1);
    instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k >= 4) check($sformatf("stall_req_valid_c%0d", k + 1), 32'(imem_req_valid), 32'd0);
    end
    check("stall_accepted", 32'(acc_log.size()), 32'(DEPTH));
    check("stall_head_valid", 32'(instr_valid), 32'd1);
    check("stall_head_pc", instr_pc, 32'h0);
    check("stall_head_ins", instr, mdata(32'h0));
    instr_ready = 1'b1;
    run(12);
    check("drain_pc0", pop_pc(0), 32'h0);
    check("drain_pc1", pop_pc(1), 32'h4);
    check("drain_ins1", pop_ins(1), mdata(32'h4));
    check("drain_pc2", pop_pc(2), 32'h8);
    check("drain_pc3", pop_pc(3), 32'hC);

    // Redirect with two requests in flight (3-cycle memory).
    do_reset(3);
    run(3);
    check("fly_inflight", 32'(acc_log.size()), 32'd2);
    do_redirect(32'h100, 12'h008);
    run(15);
    check("fly_req0", acc_at(0), 32'h110);
    check("fly_req1", acc_at(1), 32'h114);
    check("fly_pc0", pop_pc(0), 32'h110);
    check("fly_ins0", pop_ins(0), mdata(32'h110));
    check("fly_pc1", pop_pc(1), 32'h114);

    // Negative offset wraps; redirect beats a same-cycle pop.
    do_reset(1);
    run(3);
    check("neg_iv_before", 32'(instr_valid), 32'd1);
    do_redirect(32'h0, 12'hFFE);
    check("neg_iv_after", 32'(instr_valid), 32'd0);
    run(10);
    check("neg_req0", acc_at(0), 32'hFFFF_FFFC);
    check("neg_req1", acc_at(1), 32'h0);
    check("neg_pc0", pop_pc(0), 32'hFFFF_FFFC);
    check("neg_ins0", pop_ins(0), mdata(32'hFFFF_FFFC));
    check("neg_pc1", pop_pc(1), 32'h0);

    // Redirect while request 0x8 is held by the memory.
    do_reset(1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (imem_req_valid && imem_req_addr == 32'h8) found = 1'b1;
      else cyc();
    end
    check("held_found", 32'(found), 32'd1);
    imem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      check($sformatf("held_pre_addr%0d", k), imem_req_addr, 32'h8);
    end
    do_redirect(32'h40, 12'h000);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("held_post_valid%0d", k), 32'(imem_req_valid), 32'd1);
      check($sformatf("held_post_addr%0d", k), imem_req_addr, 32'h8);
      cyc();
    end
    imem_req_ready = 1'b1;
    run(12);
    check("held_req0", acc_at(0), 32'h8);
    check("held_req1", acc_at(1), 32'h40);
    check("held_req2", acc_at(2), 32'h44);
    check("held_pc0", pop_pc(0), 32'h40);
    check("held_ins0", pop_ins(0), mdata(32'h40));

    // Reset in mid-operation with buffered data and requests outstanding.
    do_reset(3);
    instr_ready = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (instr_valid) found = 1'b1;
      else cyc();
    end
    check("mid_buffered", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("mid_rst_req_addr", imem_req_addr, 32'h0);
    check("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_instr_pc", instr_pc, 32'h0);
    run(2);
    #2;
    rst = 1'b0;
    acc_log.delete();
    pop_log.delete();
    instr_ready = 1'b1;
    check("mid_rel_req_valid", 32'(imem_req_valid), 32'd0);
    cyc();
    check("mid_first_req_valid", 32'(imem_req_valid), 32'd1);
    check("mid_first_req_addr", imem_req_addr, 32'h0);
    run(12);
    check("mid_pc0", pop_pc(0), 32'h0);
    check("mid_ins0", pop_ins(0), mdata(32'h0));
    check("mid_pc1", pop_pc(1), 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
